// File: rtl/vec_pkg.sv
// Shared types and constants for the vector execute unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_pkg;

   typedef enum logic [3:0] {
      ADD    = 4'd0,
      SUB    = 4'd1,
      AND    = 4'd2,
      ORR    = 4'd3,
      XOR    = 4'd4,
      MOV    = 4'd5,
      REDSUM = 4'd6
   } vec_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } vec_state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational vector ALU: a, b, op -> result and NZCV.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent decides when results are captured.
// Ports: a/b lane operands, op (vec_op_e code), result, n/z/c/v lane flags.
// Build option: VEC_SAT_EN makes ADD/SUB saturate signed instead of wrapping.
module vec_lane_alu
   import vec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v
);

   logic [WIDTH:0] sum_w;
   logic [WIDTH:0] dif_w;
   logic           ovf_add;
   logic           ovf_sub;
   logic           known_op;

   // SUB as a + ~b + 1 so the carry-out directly means "no borrow".
   assign sum_w   = {1'b0, a} + {1'b0, b};
   assign dif_w   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
   assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);

`ifdef VEC_SAT_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   always_comb begin
      result   = '0;
      c        = 1'b0;
      v        = 1'b0;
      known_op = 1'b1;
      case (vec_op_e'(op))
         ADD: begin
            result = sum_w[WIDTH-1:0];
            c      = sum_w[WIDTH];
            v      = ovf_add;
`ifdef VEC_SAT_EN
            // Overflow direction follows the sign of a (both operands share it).
            if (ovf_add) result = a[WIDTH-1] ? SMIN : SMAX;
`endif
         end
         SUB: begin
            result = dif_w[WIDTH-1:0];
            c      = dif_w[WIDTH];
            v      = ovf_sub;
`ifdef VEC_SAT_EN
            if (ovf_sub) result = a[WIDTH-1] ? SMIN : SMAX;
`endif
         end
         AND:    result = a & b;
         ORR:    result = a | b;
         XOR:    result = a ^ b;
         MOV:    result = b;
         REDSUM: result = '0;   // the reduction is formed in the parent
         default: begin
            result   = a;
            known_op = 1'b0;
         end
      endcase
      n = known_op & result[WIDTH-1];
      z = (result == '0);
   end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-beat vector execute unit: one ALU op over LANES lanes, LANES_PER_CYCLE lanes per beat.
// Latency: out_valid rises LANES/LANES_PER_CYCLE cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready or flush.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_op/in_a/in_b/in_mask,
//        flush, out_valid/out_ready/out_data/out_flags ([3]=N [2]=Z [1]=C [0]=V).
// Build option: VEC_SAT_EN (signed saturating ADD/SUB, see vec_lane_alu).
module vec_exec_unit
   import vec_pkg::*;
#(
   parameter int LANES           = 16,
   parameter int WIDTH           = 32,
   parameter int LANES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_op,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic [LANES-1:0]       in_mask,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [3:0]             out_flags
);

   localparam int NBEATS = LANES / LANES_PER_CYCLE;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   if (LANES % LANES_PER_CYCLE != 0) begin : g_bad_cfg
      $error("vec_exec_unit: LANES must be a multiple of LANES_PER_CYCLE");
   end

   typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

   vec_state_e       state_q, state_d;
   logic [3:0]       op_q, op_d;
   lanes_t           a_q, a_d, b_q, b_d, res_q, res_d;
   logic [LANES-1:0] mask_q, mask_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             zacc_q, zacc_d;
   logic [3:0]       flags_q, flags_d;

   logic [LIDX_W-1:0]          lane_idx [LANES_PER_CYCLE];
   logic [WIDTH-1:0]           alu_res  [LANES_PER_CYCLE];
   logic [LANES_PER_CYCLE-1:0] alu_n, alu_z, alu_c, alu_v;
   logic                       last_beat;
   logic                       unused_lane_flags;

   assign last_beat = (beat_q == LAST_BEAT);

   for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_alu
      assign lane_idx[j] = LIDX_W'(int'(beat_q) * LANES_PER_CYCLE + j);
      vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
         .a      (a_q[lane_idx[j]]),
         .b      (b_q[lane_idx[j]]),
         .op     (op_q),
         .result (alu_res[j]),
         .n      (alu_n[j]),
         .z      (alu_z[j]),
         .c      (alu_c[j]),
         .v      (alu_v[j])
      );
   end

   // N/C/V matter only for the top lane, which is the last ALU slot of the last beat.
   assign unused_lane_flags = ^{alu_n, alu_c, alu_v};

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)      state_d = ST_BUSY;
         ST_BUSY: if (flush)         state_d = ST_IDLE;
                  else if (last_beat) state_d = ST_DONE;
         ST_DONE: if (flush || out_ready) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   assign out_data  = res_q;
   assign out_flags = flags_q;

   // ---- Datapath ----
   always_comb begin
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      mask_d  = mask_q;
      beat_d  = beat_q;
      acc_d   = acc_q;
      zacc_d  = zacc_q;
      res_d   = res_q;
      flags_d = flags_q;
      if (state_q == ST_IDLE && in_valid) begin
         op_d   = in_op;
         a_d    = in_a;
         b_d    = in_b;
         mask_d = in_mask;
         beat_d = '0;
         acc_d  = '0;
         zacc_d = 1'b1;
      end else if (state_q == ST_BUSY && !flush) begin
         for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            if (op_q == REDSUM)            res_d[lane_idx[j]] = '0;
            else if (mask_q[lane_idx[j]])  res_d[lane_idx[j]] = alu_res[j];
            else                           res_d[lane_idx[j]] = a_q[lane_idx[j]];
            if (mask_q[lane_idx[j]]) begin
               zacc_d = zacc_d & alu_z[j];
               acc_d  = acc_d + a_q[lane_idx[j]];
            end
         end
         beat_d = beat_q + 1'b1;
         if (last_beat) begin
            flags_d = '0;
            if (op_q == REDSUM) begin
               res_d[0]        = acc_d;
               flags_d[FLAG_N] = acc_d[WIDTH-1];
               flags_d[FLAG_Z] = (acc_d == '0);
            end else if (op_q <= 4'(MOV)) begin
               flags_d[FLAG_N] = mask_q[LANES-1] & alu_n[LANES_PER_CYCLE-1];
               flags_d[FLAG_Z] = zacc_d;
               flags_d[FLAG_C] = mask_q[LANES-1] & alu_c[LANES_PER_CYCLE-1];
               flags_d[FLAG_V] = mask_q[LANES-1] & alu_v[LANES_PER_CYCLE-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mask_q  <= '0;
         beat_q  <= '0;
         acc_q   <= '0;
         zacc_q  <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mask_q  <= mask_d;
         beat_q  <= beat_d;
         acc_q   <= acc_d;
         zacc_q  <= zacc_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed self-checking bench for vec_exec_unit with default parameters.
// Latency: expects out_valid 4 cycles after the accept edge.
// Backpressure: exercises out_ready hold-off, flush and async reset.
module tb_vec_exec_unit;

   typedef logic [15:0][31:0] vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'd0;
   vec_t        in_a = '0;
   vec_t        in_b = '0;
   logic [15:0] in_mask = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [511:0] out_data;
   logic [3:0]  out_flags;

   int checks   = 0;
   int failures = 0;

   vec_exec_unit #(.LANES(16), .WIDTH(32), .LANES_PER_CYCLE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mask   (in_mask),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input vec_t a, input vec_t b,
                         input logic [15:0] mask, input vec_t exp_d, input logic [3:0] exp_f);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      chk({tag, "_rdy_idle"}, in_ready, 1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_mask = mask;
      tick();
      in_valid = 1'b0;
      chk({tag, "_rdy_busy"}, in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_data"}, out_data, exp_d);
      chk({tag, "_flags"}, out_flags, exp_f);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_retired"}, out_valid, 0);
   endtask

   vec_t a_idx, b_100, exp_v, va, vb, v_and;
   int   seen;
   int   w;

   initial begin
      for (int i = 0; i < 16; i++) begin
         a_idx[i] = 32'(i);
         b_100[i] = 32'd100;
      end

      // Reset state
      #1 rst = 1'b0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_flags", out_flags, 0);
      rst = 1'b1;
      tick();

      // ADD a[i]=i + 100
      for (int i = 0; i < 16; i++) exp_v[i] = 32'(100 + i);
      run_op("add_basic", 4'd0, a_idx, b_100, 16'hFFFF, exp_v, 4'b0000);

      // SUB: lane15 0-1, others 5-5
      for (int i = 0; i < 16; i++) begin va[i] = 32'd5; vb[i] = 32'd5; exp_v[i] = 32'd0; end
      va[15] = 32'h0; vb[15] = 32'h1; exp_v[15] = 32'hFFFF_FFFF;
      run_op("sub_borrow", 4'd1, va, vb, 16'hFFFF, exp_v, 4'b1000);

      // REDSUM over lanes 0..7 -> 28
      exp_v = '0; exp_v[0] = 32'd28;
      run_op("redsum_ff", 4'd6, a_idx, b_100, 16'h00FF, exp_v, 4'b0000);

      // REDSUM with nothing active
      exp_v = '0;
      run_op("redsum_m0", 4'd6, a_idx, b_100, 16'h0000, exp_v, 4'b0100);

      // ADD with nothing active merges A, Z=1
      run_op("add_m0", 4'd0, a_idx, b_100, 16'h0000, a_idx, 4'b0100);

      // ADD with only lane 0 active
      exp_v = a_idx; exp_v[0] = 32'd100;
      run_op("add_m1", 4'd0, a_idx, b_100, 16'h0001, exp_v, 4'b0000);

      // Undefined opcode returns A, flags 0
      run_op("undef_op", 4'hF, a_idx, b_100, 16'hFFFF, a_idx, 4'b0000);

      // MOV returns B; lane15 negative
      for (int i = 0; i < 16; i++) vb[i] = 32'hA000_0000 + 32'(i);
      run_op("mov", 4'd5, a_idx, vb, 16'hFFFF, vb, 4'b1000);

      // Signed overflow on lane15
      va = '0; vb = '0; va[15] = 32'h7FFF_FFFF; vb[15] = 32'h1;
      exp_v = '0;
`ifdef VEC_SAT_EN
      exp_v[15] = 32'h7FFF_FFFF;
      run_op("add_ovf", 4'd0, va, vb, 16'hFFFF, exp_v, 4'b0001);
`else
      exp_v[15] = 32'h8000_0000;
      run_op("add_ovf", 4'd0, va, vb, 16'hFFFF, exp_v, 4'b1001);
`endif

      // Carry out to zero on lane15: Z=1, C=1
      va = '0; vb = '0; va[15] = 32'hFFFF_FFFF; vb[15] = 32'h1;
      exp_v = '0;
      run_op("add_carry", 4'd0, va, vb, 16'hFFFF, exp_v, 4'b0110);

      // Hold in DONE with out_ready low while in_valid is offered
      for (int i = 0; i < 16; i++) begin
         va[i] = 32'hF0F0_F0F0; vb[i] = 32'hFF00_FF00; v_and[i] = 32'hF000_F000;
      end
      in_valid = 1'b1; in_op = 4'd2; in_a = va; in_b = vb; in_mask = 16'hFFFF;
      tick();
      w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
      chk("hold_reach_done", out_valid, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, v_and);
         chk("hold_flags", out_flags, 4'b1000);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("hold_release_valid", out_valid, 0);
      chk("hold_release_ready", in_ready, 1);
      tick();
      chk("no_turnaround", in_ready, 1);

      // Flush at beat 2
      in_valid = 1'b1; in_op = 4'd0; in_a = a_idx; in_b = b_100; in_mask = 16'hFFFF;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_idle", in_ready, 1);
      chk("flush_valid", out_valid, 0);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (out_valid) seen = 1;
         tick();
      end
      chk("flush_never_valid", seen, 0);

      for (int i = 0; i < 16; i++) begin va[i] = 32'd1; exp_v[i] = 32'd2; end
      run_op("after_flush", 4'd0, va, va, 16'hFFFF, exp_v, 4'b0000);

      // Async reset mid-BUSY
      in_valid = 1'b1; in_op = 4'd0; in_a = a_idx; in_b = b_100; in_mask = 16'hFFFF;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_flags", out_flags, 0);
      chk("arst_ready", in_ready, 1);
      tick();
      rst = 1'b1;
      tick();
      chk("arst_stays_idle", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
